dual_port_ram: RTL and testbench

DUAL_PORT_RAM -- requirements
Module: dual_port_ram

---
 rtl/dual_port_ram.sv | 138 +++++++++++++
 tb/tb_dual_port_ram.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_ram.sv
// dual_port_ram: two symmetric read/write ports with byte enables on a
// single clock, plus a sweep engine that clears the whole array.
//
// Ports:
//   clk, rst            - rising-edge clock, synchronous active-high reset
//   a_en/a_we/a_addr/a_din/a_dout - port A: enable, byte write enables,
//                          address, write data, registered read data
//   b_*                 - port B, identical to port A
//   clr_req             - request a full-memory clear (honoured in READY only)
//   busy                - high while the clear sweep owns the array
//
// Behaviour summary:
//   - Read latency 1 cycle; dout holds when its port is disabled.
//   - Same-port read-during-write: old word (WRITE_FIRST=0) or the word merged
//     with this port's own write bytes (WRITE_FIRST=1).
//   - Cross-port reads always see the pre-write word.
//   - Same address/byte written by both ports: port A wins.
//   - Addresses >= DEPTH: writes dropped, reads return 0.
module dual_port_ram #(
  parameter int                    N           = 4,
  parameter int                    DEPTH       = 16,
  parameter int                    DATA_WIDTH  = 8,
  parameter bit                    WRITE_FIRST = 1'b0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a_en,
  input  logic [DATA_WIDTH/8-1:0] a_we,
  input  logic [N-1:0]            a_addr,
  input  logic [DATA_WIDTH-1:0]   a_din,
  output logic [DATA_WIDTH-1:0]   a_dout,
  input  logic                    b_en,
  input  logic [DATA_WIDTH/8-1:0] b_we,
  input  logic [N-1:0]            b_addr,
  input  logic [DATA_WIDTH-1:0]   b_din,
  output logic [DATA_WIDTH-1:0]   b_dout,
  input  logic                    clr_req,
  output logic                    busy
);

  localparam int unsigned NB      = DATA_WIDTH / 8;
  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [N:0]  DEPTH_L = (N + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  state_t                state;
  logic [AW-1:0]         cnt;

  logic                  a_hit, b_hit;
  logic [AW-1:0]         a_idx, b_idx;
  logic [DATA_WIDTH-1:0] a_old, b_old;
  logic [DATA_WIDTH-1:0] a_rd, b_rd;

  // Address decode and read-data selection. In write-first mode each port
  // only merges its own write bytes, so the other port's write never leaks
  // into this port's read result.
  always_comb begin
    a_hit = {1'b0, a_addr} < DEPTH_L;
    b_hit = {1'b0, b_addr} < DEPTH_L;
    a_idx = a_addr[AW-1:0];
    b_idx = b_addr[AW-1:0];
    a_old = a_hit ? mem[a_idx] : '0;
    b_old = b_hit ? mem[b_idx] : '0;
    a_rd  = a_old;
    b_rd  = b_old;
    if (WRITE_FIRST) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (a_hit && a_we[i]) a_rd[8*i +: 8] = a_din[8*i +: 8];
        if (b_hit && b_we[i]) b_rd[8*i +: 8] = b_din[8*i +: 8];
      end
    end
  end

  // Array update. Port B is applied before port A so that, for a byte both
  // ports write at the same address, A's non-blocking update lands last.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[cnt] <= INIT_VALUE;
      end else begin
        if (b_en && b_hit) begin
          for (int unsigned i = 0; i < NB; i++) begin
            if (b_we[i]) mem[b_idx][8*i +: 8] <= b_din[8*i +: 8];
          end
        end
        if (a_en && a_hit) begin
          for (int unsigned i = 0; i < NB; i++) begin
            if (a_we[i]) mem[a_idx][8*i +: 8] <= a_din[8*i +: 8];
          end
        end
      end
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= CLEAR;
      cnt    <= '0;
      busy   <= 1'b1;
      a_dout <= '0;
      b_dout <= '0;
    end else begin
      case (state)
        CLEAR: begin
          a_dout <= '0;
          b_dout <= '0;
          if (cnt == LAST) begin
            state <= READY;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        READY: begin
          if (a_en) a_dout <= a_rd;
          if (b_en) b_dout <= b_rd;
          if (clr_req) begin
            state <= CLEAR;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        default: begin
          state <= CLEAR;
          busy  <= 1'b1;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dual_port_ram.sv
// tb_dual_port_ram: drives two instances of dual_port_ram from one shared
// stimulus stream and compares every cycle against a behavioural model.
//   u0: defaults (N=4, DEPTH=16, 8-bit words, read-first, INIT 0)
//   u1: N=5, DEPTH=16, 16-bit words, write-first, INIT 16'hBEEF
module tb_dual_port_ram;

  logic        clk = 1'b0;
  logic        rst, clr_req;
  logic        a_en, b_en;
  logic [1:0]  a_we, b_we;
  logic [4:0]  a_addr, b_addr;
  logic [15:0] a_din, b_din;

  logic [7:0]  a_dout0, b_dout0;
  logic [15:0] a_dout1, b_dout1;
  logic        busy0, busy1;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  dual_port_ram u0 (
    .clk(clk), .rst(rst),
    .a_en(a_en), .a_we(a_we[0:0]), .a_addr(a_addr[3:0]), .a_din(a_din[7:0]), .a_dout(a_dout0),
    .b_en(b_en), .b_we(b_we[0:0]), .b_addr(b_addr[3:0]), .b_din(b_din[7:0]), .b_dout(b_dout0),
    .clr_req(clr_req), .busy(busy0)
  );

  dual_port_ram #(
    .N(5), .DEPTH(16), .DATA_WIDTH(16), .WRITE_FIRST(1'b1), .INIT_VALUE(16'hBEEF)
  ) u1 (
    .clk(clk), .rst(rst),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout1),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout1),
    .clr_req(clr_req), .busy(busy1)
  );

  // Reference model state, one slot per instance.
  logic [15:0] mm [2][32];
  bit          clearing [2];
  int          cnt [2];
  logic [15:0] exp_a [2];
  logic [15:0] exp_b [2];
  bit          exp_busy [2];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One rising edge worth of behaviour for instance k.
  task automatic model_edge(input int k);
    int          aw, nb, aa, bb;
    bit          wf;
    logic [15:0] initv, old_a, old_b, mrg_a, mrg_b;
    aw    = (k == 0) ? 4 : 5;
    nb    = (k == 0) ? 1 : 2;
    wf    = (k == 1);
    initv = (k == 0) ? 16'h0000 : 16'hBEEF;
    aa    = int'(a_addr) % (1 << aw);
    bb    = int'(b_addr) % (1 << aw);
    if (rst) begin
      exp_a[k] = '0; exp_b[k] = '0; clearing[k] = 1; cnt[k] = 0;
    end else if (clearing[k]) begin
      mm[k][cnt[k]] = initv;
      cnt[k]++;
      if (cnt[k] == 16) clearing[k] = 0;
      exp_a[k] = '0; exp_b[k] = '0;
    end else begin
      old_a = (aa < 16) ? mm[k][aa] : 16'h0000;
      old_b = (bb < 16) ? mm[k][bb] : 16'h0000;
      mrg_a = old_a;
      mrg_b = old_b;
      for (int i = 0; i < nb; i++) begin
        if (a_we[i]) mrg_a[8*i +: 8] = a_din[8*i +: 8];
        if (b_we[i]) mrg_b[8*i +: 8] = b_din[8*i +: 8];
      end
      if (aa >= 16) mrg_a = '0;
      if (bb >= 16) mrg_b = '0;
      if (b_en && bb < 16)
        for (int i = 0; i < nb; i++) if (b_we[i]) mm[k][bb][8*i +: 8] = b_din[8*i +: 8];
      if (a_en && aa < 16)
        for (int i = 0; i < nb; i++) if (a_we[i]) mm[k][aa][8*i +: 8] = a_din[8*i +: 8];
      if (a_en) exp_a[k] = wf ? mrg_a : old_a;
      if (b_en) exp_b[k] = wf ? mrg_b : old_b;
      if (clr_req) begin clearing[k] = 1; cnt[k] = 0; end
    end
    exp_busy[k] = clearing[k];
  endtask

  // Inputs are changed only after a negedge; the model samples them at the
  // posedge and the outputs are compared at the following negedge.
  task automatic tick();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
    check("busy0",   {15'h0, busy0},   {15'h0, exp_busy[0]});
    check("busy1",   {15'h0, busy1},   {15'h0, exp_busy[1]});
    check("a_dout0", {8'h0, a_dout0},  {8'h0, exp_a[0][7:0]});
    check("b_dout0", {8'h0, b_dout0},  {8'h0, exp_b[0][7:0]});
    check("a_dout1", a_dout1, exp_a[1]);
    check("b_dout1", b_dout1, exp_b[1]);
  endtask

  task automatic idle();
    rst = 0; clr_req = 0; a_en = 0; b_en = 0; a_we = '0; b_we = '0;
    a_addr = '0; b_addr = '0; a_din = '0; b_din = '0;
  endtask

  task automatic wr_a(input logic [4:0] addr, input logic [15:0] d, input logic [1:0] we);
    idle(); a_en = 1; a_addr = addr; a_din = d; a_we = we; tick();
  endtask

  task automatic rd_a(input logic [4:0] addr);
    idle(); a_en = 1; a_addr = addr; tick();
  endtask

  // Counts ticks until busy0 drops, with a hard bound.
  task automatic count_busy(input string tag, input bit clr_mid);
    int n;
    n = 0;
    while (busy0 && n < 40) begin
      if (clr_mid) clr_req = (n == 3 || n == 10);
      tick();
      n++;
    end
    clr_req = 0;
    check(tag, 16'(n), 16'd16);
  endtask

  initial begin
    idle();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 32; i++) mm[k][i] = '0;

    // Reset for one cycle, then a full sweep with reads of every word.
    rst = 1; tick();
    check("rst_busy", {15'h0, busy0}, 16'h0001);
    check("rst_dout", {8'h0, a_dout0}, 16'h0000);
    rst = 0;
    count_busy("clear_len_rst", 1'b0);
    for (int i = 0; i < 16; i++) begin
      idle(); a_en = 1; b_en = 1; a_addr = 5'(i); b_addr = 5'(15 - i); tick();
      check("clr_word0", {8'h0, a_dout0}, 16'h0000);
    end

    // A writes, B reads back one cycle later.
    wr_a(5'd3, 16'h00A5, 2'b11);
    idle(); b_en = 1; b_addr = 5'd3; tick();
    check("a_to_b", {8'h0, b_dout0}, 16'h00A5);

    // Both ports write the same address: A wins.
    idle(); a_en = 1; b_en = 1; a_addr = 5'd5; b_addr = 5'd5;
    a_din = 16'h0011; b_din = 16'h0022; a_we = 2'b11; b_we = 2'b11; tick();
    rd_a(5'd5);
    check("collide0", {8'h0, a_dout0}, 16'h0011);
    check("collide1", a_dout1, 16'h0011);

    // Read-during-write on port A.
    wr_a(5'd2, 16'h0033, 2'b11);
    wr_a(5'd2, 16'h0044, 2'b11);
    check("rdw_rf", {8'h0, a_dout0}, 16'h0033);
    check("rdw_wf", a_dout1, 16'h0044);
    rd_a(5'd2);
    check("rdw_after", {8'h0, a_dout0}, 16'h0044);

    // Byte enables on the 16-bit instance, then an out-of-range read.
    wr_a(5'd1, 16'h1234, 2'b11);
    wr_a(5'd1, 16'hABCD, 2'b01);
    rd_a(5'd1);
    check("byte_we", a_dout1, 16'h12CD);
    rd_a(5'd16);
    check("oor_read", a_dout1, 16'h0000);
    wr_a(5'd17, 16'h5555, 2'b11);
    rd_a(5'd1);
    check("oor_write", a_dout1, 16'h12CD);

    // clr_req in READY (with clr_req repeated mid-sweep), then all words.
    idle(); clr_req = 1; tick();
    clr_req = 0;
    count_busy("clear_len_req", 1'b1);
    for (int i = 0; i < 16; i++) begin
      rd_a(5'(i));
      check("reclr_word0", {8'h0, a_dout0}, 16'h0000);
      check("reclr_word1", a_dout1, 16'hBEEF);
    end

    // Reset pulse at sweep cycle 7 restarts the sweep.
    idle(); clr_req = 1; tick();
    clr_req = 0;
    for (int i = 0; i < 7; i++) tick();
    rst = 1; tick();
    rst = 0;
    count_busy("clear_len_midrst", 1'b0);

    // Randomized traffic with occasional clears and resets.
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 499) == 0);
      clr_req = ($urandom_range(0, 199) == 0);
      a_en    = $urandom_range(0, 1);
      b_en    = $urandom_range(0, 1);
      a_we    = 2'($urandom);
      b_we    = 2'($urandom);
      a_addr  = 5'($urandom);
      b_addr  = ($urandom_range(0, 3) == 0) ? a_addr : 5'($urandom);
      a_din   = 16'($urandom);
      b_din   = 16'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
